count_bank: RTL and testbench

COUNT_BANK -- requirements
Module: count_bank

---
 rtl/count_bank.sv | 98 +++++++++
 tb/tb_count_bank.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/count_bank.sv
// rtl/count_bank.sv - bank of independent up/down counters with load, terminal-count pulse and snapshot
// Build with COUNT_BANK_SAT_EN defined to make boundary steps saturate instead of wrapping.
module count_bank #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  input  logic                      snap,
  output logic [CHANNELS*WIDTH-1:0] cnt,
  output logic [CHANNELS*WIDTH-1:0] cnt_snap,
  output logic [CHANNELS-1:0]       tc,
  output logic                      snap_vld
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]    cnt_q  [CHANNELS];
  logic [WIDTH-1:0]    snap_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_nxt[CHANNELS];
  logic [CHANNELS-1:0] boundary;
  logic [CHANNELS-1:0] tc_q;
  logic                snap_vld_q;

  // Next count per channel; boundary flags an enabled step past either end of the range.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i]  = cnt_q[i];
      boundary[i] = 1'b0;
      if (load[i]) begin
        cnt_nxt[i] = load_val[i*WIDTH +: WIDTH];
      end else if (en[i]) begin
        if (dir[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            boundary[i] = 1'b1;
`ifdef COUNT_BANK_SAT_EN
            cnt_nxt[i] = CNT_MAX;
`else
            cnt_nxt[i] = '0;
`endif
          end else begin
            cnt_nxt[i] = cnt_q[i] + CNT_ONE;
          end
        end else begin
          if (cnt_q[i] == '0) begin
            boundary[i] = 1'b1;
`ifdef COUNT_BANK_SAT_EN
            cnt_nxt[i] = '0;
`else
            cnt_nxt[i] = CNT_MAX;
`endif
          end else begin
            cnt_nxt[i] = cnt_q[i] - CNT_ONE;
          end
        end
      end
    end
  end

  // The snapshot takes the post-edge counts so loads and steps in the snap cycle are included.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      tc_q       <= '0;
      snap_vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_nxt[i];
        if (snap) begin
          snap_q[i] <= cnt_nxt[i];
        end
      end
      tc_q       <= boundary;
      snap_vld_q <= snap;
    end
  end

  always_comb begin
    cnt      = '0;
    cnt_snap = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt[i*WIDTH +: WIDTH]      = cnt_q[i];
      cnt_snap[i*WIDTH +: WIDTH] = snap_q[i];
    end
  end

  assign tc       = tc_q;
  assign snap_vld = snap_vld_q;

endmodule

// File: tb/tb_count_bank.sv
// tb/tb_count_bank.sv - self-checking bench for count_bank against a behavioural model
// Honours COUNT_BANK_SAT_EN in the model so either build can be checked.
module tb_count_bank;

  localparam int W    = 3;
  localparam int CH   = 5;
  localparam int MAXV = (1 << W) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   en, dir, load;
  logic [CH*W-1:0] load_val;
  logic            snap;
  logic [CH*W-1:0] cnt, cnt_snap;
  logic [CH-1:0]   tc;
  logic            snap_vld;

  int compared   = 0;
  int mismatched = 0;

  int m_cnt [CH];
  int m_snap[CH];
  bit m_tc  [CH];
  bit m_vld;

  count_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .snap(snap), .cnt(cnt), .cnt_snap(cnt_snap), .tc(tc), .snap_vld(snap_vld)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0; m_snap[i] = 0; m_tc[i] = 0;
      end
      m_vld = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        int t;
        m_tc[i] = 0;
        if (load[i]) begin
          m_cnt[i] = int'(load_val[i*W +: W]);
        end else if (en[i]) begin
          t = m_cnt[i] + (dir[i] ? 1 : -1);
          if (t < 0 || t > MAXV) begin
            m_tc[i] = 1;
`ifdef COUNT_BANK_SAT_EN
            t = (t < 0) ? 0 : MAXV;
`else
            t = (t + MAXV + 1) % (MAXV + 1);
`endif
          end
          m_cnt[i] = t;
        end
      end
      if (snap) begin
        for (int i = 0; i < CH; i++) m_snap[i] = m_cnt[i];
      end
      m_vld = snap;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < CH; i++) begin
      logic [W-1:0] exp_c, exp_s;
      exp_c = W'(m_cnt[i]);
      exp_s = W'(m_snap[i]);
      compared++;
      assert (cnt[i*W +: W] === exp_c) else begin
        mismatched++;
        $error("FAIL %s cnt[%0d] observed %0d expected %0d", tag, i, cnt[i*W +: W], exp_c);
      end
      compared++;
      assert (cnt_snap[i*W +: W] === exp_s) else begin
        mismatched++;
        $error("FAIL %s cnt_snap[%0d] observed %0d expected %0d", tag, i, cnt_snap[i*W +: W], exp_s);
      end
      compared++;
      assert (tc[i] === m_tc[i]) else begin
        mismatched++;
        $error("FAIL %s tc[%0d] observed %b expected %b", tag, i, tc[i], m_tc[i]);
      end
    end
    compared++;
    assert (snap_vld === m_vld) else begin
      mismatched++;
      $error("FAIL %s snap_vld observed %b expected %b", tag, snap_vld, m_vld);
    end
  endtask

  // One clock: inputs already applied, model advances at the edge, outputs checked 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    rst = 0; en = '0; dir = '0; load = '0; load_val = '0; snap = 0;
  endtask

  task automatic set_lv(input int ch, input int val);
    load_val[ch*W +: W] = W'(val);
  endtask

  initial begin
    idle_inputs();

    // Reset overrides load, en and snap.
    rst = 1; load = '1; en = '1; dir = '1; snap = 1; load_val = '1;
    step("reset");
    idle_inputs();
    step("post_reset_hold");

    // ch0 counts up through the wrap.
    en[0] = 1; dir[0] = 1;
    for (int k = 0; k < 8; k++) step("ch0_up");
    en[0] = 0;
    step("ch0_after");

    // ch1 load wins over enable, then counts down through zero.
    set_lv(1, 2); load[1] = 1; en[1] = 1; dir[1] = 1;
    step("ch1_load");
    load[1] = 0; dir[1] = 0;
    for (int k = 0; k < 3; k++) step("ch1_down");
    idle_inputs();
    step("ch1_after");

    // ch2 snap in the same cycle as a step, then snapshot holds.
    set_lv(2, 6); load[2] = 1;
    step("ch2_load");
    load[2] = 0; en[2] = 1; dir[2] = 1; snap = 1;
    step("ch2_snap");
    snap = 0;
    for (int k = 0; k < 3; k++) step("ch2_continue");
    idle_inputs();

    // ch3 at the top, stepping up (saturates or wraps depending on build).
    set_lv(3, 7); load[3] = 1;
    step("ch3_load");
    load[3] = 0; en[3] = 1; dir[3] = 1;
    for (int k = 0; k < 3; k++) step("ch3_top");
    idle_inputs();

    // ch4 reset mid-count, then restart from zero.
    set_lv(4, 5); load[4] = 1;
    step("ch4_load");
    load[4] = 0; en[4] = 1; dir[4] = 1;
    step("ch4_count");
    rst = 1;
    step("ch4_rst");
    rst = 0;
    step("ch4_restart");
    idle_inputs();
    step("ch4_hold");

    // Randomised traffic on all channels.
    for (int k = 0; k < 400; k++) begin
      en  = CH'($urandom);
      dir = CH'($urandom);
      load = '0;
      for (int i = 0; i < CH; i++) load[i] = ($urandom_range(0, 7) == 0);
      load_val = (CH*W)'($urandom);
      snap = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 63) == 0);
      step("random");
    end
    idle_inputs();
    step("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
